// File: rtl/quadgen_pkg.sv
// Shared types for Quadgen and its upstream command sequencer.
//   QG_W       : Quadgen operand/result width
//   qg_func_t  : Quadgen operation select
//   qg_cmd_t   : one queued Quadgen operation {func, a, b}
//   seq_state_t: command sequencer FSM states
package quadgen_pkg;

    localparam int unsigned QG_W = 4;

    typedef logic [1:0] qg_func_t;

    typedef struct packed {
        qg_func_t          func;
        logic [QG_W-1:0]   a;
        logic [QG_W-1:0]   b;
    } qg_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/quadgen_cmd_fifo.sv
// Synchronous command FIFO for the Quadgen sequencer.
//   clk, rst      : clock, async active-high reset (flushes pointers/count)
//   push, wdata   : write request and entry (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head
//   count         : occupancy, 0..DEPTH
//   full, empty   : occupancy flags decoded from count
module quadgen_cmd_fifo
    import quadgen_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  qg_cmd_t                wdata,
    input  logic                   pop,
    output qg_cmd_t                rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    qg_cmd_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/quadgen_cmd_seq.sv
// Upstream command sequencer for Quadgen: queues (func, a, b) commands,
// issues them one at a time, waits LAT edges for the registered result and
// presents {result, func} on a valid/ready output in acceptance order.
//   clk, rst                    : clock, async active-high reset
//   in_valid/in_ready           : command handshake (in_ready = count < DEPTH)
//   in_func, in_a, in_b         : command payload
//   qg_func, qg_a, qg_b         : registered drive to Quadgen, change only on pop
//   qg_result                   : Quadgen registered result
//   out_valid/out_ready         : result handshake
//   out_result, out_func        : captured result and originating func
//   count                       : FIFO occupancy
//   busy                        : FSM not in IDLE
module quadgen_cmd_seq
    import quadgen_pkg::*;
#(
    parameter int unsigned W     = QG_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_func,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic [1:0]             qg_func,
    output logic [W-1:0]           qg_a,
    output logic [W-1:0]           qg_b,
    input  logic [W-1:0]           qg_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_result,
    output logic [1:0]             out_func,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT + 1) : 1;

    seq_state_t    state;
    seq_state_t    state_d;
    logic [CW-1:0] wait_cnt;
    qg_cmd_t       wr_cmd;
    qg_cmd_t       head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          issue_c;
    logic          dec_c;
    logic          capture_c;
    logic          release_c;

    assign in_ready = ~fifo_full;
    assign wr_cmd   = '{func: qg_func_t'(in_func), a: QG_W'(in_a), b: QG_W'(in_b)};

    quadgen_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid & in_ready),
        .wdata (wr_cmd),
        .pop   (issue_c),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (!fifo_empty)     state_d = WAIT;
            WAIT:    if (wait_cnt == '0)  state_d = HOLD;
            HOLD:    if (out_ready)       state_d = fifo_empty ? IDLE : WAIT;
            default:                      state_d = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        issue_c   = 1'b0;
        dec_c     = 1'b0;
        capture_c = 1'b0;
        release_c = 1'b0;
        unique case (state)
            IDLE: issue_c = ~fifo_empty;
            WAIT: begin
                capture_c = (wait_cnt == '0);
                dec_c     = (wait_cnt != '0);
            end
            HOLD: begin
                release_c = out_ready;
                issue_c   = out_ready & ~fifo_empty;  // back-to-back pop on handshake
            end
            default: ;
        endcase
    end

    // Issue, wait-count and result capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qg_func    <= '0;
            qg_a       <= '0;
            qg_b       <= '0;
            wait_cnt   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_func   <= '0;
            busy       <= 1'b0;
        end else begin
            if (issue_c) begin
                qg_func  <= head.func;
                qg_a     <= W'(head.a);
                qg_b     <= W'(head.b);
                wait_cnt <= CW'(LAT);
            end else if (dec_c) begin
                wait_cnt <= wait_cnt - CW'(1);
            end
            if (capture_c) begin
                out_result <= qg_result;
                out_func   <= qg_func;
                out_valid  <= 1'b1;
            end else if (release_c) begin
                out_valid  <= 1'b0;
            end
            busy <= (state_d != IDLE);
        end
    end

endmodule
